// File: rtl/lc3_mem_ctrl_if.sv
// lc3_mem_ctrl_if: req/ack memory port between the LC-3 memory sequencer
// (master) and the memory model or array (slave). The request fields stay
// stable while mem_req is high. mem_ack is a single-cycle completion pulse,
// and mem_rdata is valid in the same cycle as mem_ack.
interface lc3_mem_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: turns the control unit's held memRd/memWr into exactly one
// req/ack memory transaction. It returns read data to the MDR mux and gives a
// one-cycle R pulse when the access is done.
//
// Optional feature (compile-time macro LC3_MEM_TIMEOUT_EN):
//   A REQ-phase watchdog. After TIMEOUT_CYC cycles with no mem_ack, the access
//   is aborted. R and memErr then pulse together and rdData is cleared.
//   Without the macro, REQ waits indefinitely and memErr only flags rd/wr
//   conflicts.
//
// state | meaning
// IDLE  | waiting for memRd xor memWr; a simultaneous rd+wr is rejected here
// REQ   | mem_req high with latched addr/we/wdata, waiting for mem_ack
// DONE  | R pulse (plus memErr on timeout); always returns to IDLE
module lc3_mem_ctrl #(
  parameter int AW = 16,
  parameter int DW = 16
`ifdef LC3_MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memRd,
  input  logic          memWr,
  input  logic [AW-1:0] MAR,
  input  logic [DW-1:0] MDR,
  output logic [DW-1:0] rdData,
  output logic          R,
  output logic          memErr,
  lc3_mem_ctrl_if.master mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic [DW-1:0] rd_q;
  logic          conf_err_q;

  // Decoded events for the current cycle, produced by the next-state logic.
  logic accept;
  logic conflict;
  logic complete;
  logic to_hit;

`ifdef LC3_MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q;
  logic          to_err_q;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and per-cycle event strobes.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    conflict = 1'b0;
    complete = 1'b0;
    to_hit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (memRd ^ memWr) begin
          accept  = 1'b1;
          state_d = REQ;
        end else if (memRd & memWr) begin
          // Rejected without touching memory; stay put.
          conflict = 1'b1;
        end
      end
      REQ: begin
        // An ack in the same cycle as the terminal count still wins:
        // a real completion is never reported as an error.
        if (mem.mem_ack) begin
          complete = 1'b1;
          state_d  = DONE;
        end
`ifdef LC3_MEM_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          to_hit  = 1'b1;
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request capture at acceptance; memRd/memWr/MAR/MDR are ignored after that.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= MAR;
      wdata_q <= MDR;
      we_q    <= memWr;
    end
  end

  // Read-data register: only a completed read or an abort changes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (complete && !we_q) begin
      rd_q <= mem.mem_rdata;
    end else if (to_hit) begin
      rd_q <= '0;
    end
  end

  // Conflict error is a one-cycle pulse in the cycle after the rejection.
  always_ff @(posedge clk) begin
    if (rst) begin
      conf_err_q <= 1'b0;
    end else begin
      conf_err_q <= conflict;
    end
  end

`ifdef LC3_MEM_TIMEOUT_EN
  // Watchdog: clears as the request is accepted and counts REQ cycles without ack.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      cnt_q <= '0;
    end else if (state_q == REQ && !mem.mem_ack && !to_hit) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Timeout flag lines up with the DONE cycle so that memErr coincides with R.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_err_q <= 1'b0;
    end else begin
      to_err_q <= to_hit;
    end
  end

  assign memErr = conf_err_q | to_err_q;
`else
  assign memErr = conf_err_q;
`endif

  assign R             = (state_q == DONE);
  assign rdData        = rd_q;
  assign mem.mem_req   = (state_q == REQ);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl: cycle-stepped bench for lc3_mem_ctrl. The bench plays both
// the control unit and a behavioural memory (associative array). The expected
// rdData, R, memErr and bus contents come from transaction-level rules: a read
// returns the stored word, a write stores its data, a reset or timeout clears
// rdData, and R arrives one cycle after the ack.
module tb_lc3_mem_ctrl;

`ifdef LC3_MEM_TIMEOUT_EN
  localparam int MAXW = 3;
`else
  localparam int MAXW = 6;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        memRd, memWr;
  logic [15:0] MAR, MDR;
  logic [15:0] rdData;
  logic        R, memErr;

  lc3_mem_ctrl_if #(.AW(16), .DW(16)) mif ();

`ifdef LC3_MEM_TIMEOUT_EN
  lc3_mem_ctrl #(.AW(16), .DW(16), .TIMEOUT_CYC(4)) dut (
`else
  lc3_mem_ctrl #(.AW(16), .DW(16)) dut (
`endif
    .clk    (clk),
    .rst    (rst),
    .memRd  (memRd),
    .memWr  (memWr),
    .MAR    (MAR),
    .MDR    (MDR),
    .rdData (rdData),
    .R      (R),
    .memErr (memErr),
    .mem    (mif)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] mem_model [logic [15:0]];
  logic [15:0] exp_rd;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Entered just after a negedge. Leaves the bench just after the negedge of the DONE cycle.
  task automatic do_txn(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                        input int waits, input bit hold);
    logic [15:0] rv;
    memRd = !wr;
    memWr = wr;
    MAR   = addr;
    MDR   = data;
    @(posedge clk);
    rv = mem_model.exists(addr) ? mem_model[addr] : 16'($urandom);
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      chk_eq("req_high", 32'(mif.mem_req), 32'd1);
      chk_eq("req_we", 32'(mif.mem_we), 32'(wr));
      chk_eq("req_addr", 32'(mif.mem_addr), 32'(addr));
      if (wr) chk_eq("req_wdata", 32'(mif.mem_wdata), 32'(data));
      chk_eq("req_noR", 32'(R), 32'd0);
      chk_eq("req_noerr", 32'(memErr), 32'd0);
      chk_eq("req_rdhold", 32'(rdData), 32'(exp_rd));
      MAR = 16'($urandom);
      MDR = 16'($urandom);
      mif.mem_ack   = (i == waits);
      mif.mem_rdata = (i == waits) ? rv : 16'($urandom);
    end
    @(posedge clk);
    @(negedge clk);
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 16'($urandom);
    if (wr) mem_model[addr] = data;
    else begin
      mem_model[addr] = rv;
      exp_rd = rv;
    end
    chk_eq("done_R", 32'(R), 32'd1);
    chk_eq("done_err", 32'(memErr), 32'd0);
    chk_eq("done_reqlow", 32'(mif.mem_req), 32'd0);
    chk_eq("done_rdData", 32'(rdData), 32'(exp_rd));
    if (!hold) begin
      memRd = 1'b0;
      memWr = 1'b0;
    end
  endtask

  task automatic do_conflict();
    memRd = 1'b1;
    memWr = 1'b1;
    MAR   = 16'($urandom);
    @(posedge clk);
    @(negedge clk);
    memRd = 1'b0;
    memWr = 1'b0;
    chk_eq("conf_err", 32'(memErr), 32'd1);
    chk_eq("conf_noR", 32'(R), 32'd0);
    chk_eq("conf_noreq", 32'(mif.mem_req), 32'd0);
    chk_eq("conf_rd", 32'(rdData), 32'(exp_rd));
    @(posedge clk);
    @(negedge clk);
    chk_eq("conf_errclr", 32'(memErr), 32'd0);
    chk_eq("conf_noreq2", 32'(mif.mem_req), 32'd0);
  endtask

  // Idle cycles with occasional stray acks, which must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mif.mem_ack = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      mif.mem_ack = 1'b0;
      chk_eq("idle_noR", 32'(R), 32'd0);
      chk_eq("idle_noreq", 32'(mif.mem_req), 32'd0);
      chk_eq("idle_noerr", 32'(memErr), 32'd0);
      chk_eq("idle_rd", 32'(rdData), 32'(exp_rd));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          wr;
    logic [15:0] a;
    rst = 1'b1;
    memRd = 1'b0;
    memWr = 1'b0;
    MAR = '0;
    MDR = '0;
    mif.mem_ack = 1'b0;
    mif.mem_rdata = '0;
    exp_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_R", 32'(R), 32'd0);
    chk_eq("rst_err", 32'(memErr), 32'd0);
    chk_eq("rst_req", 32'(mif.mem_req), 32'd0);
    chk_eq("rst_we", 32'(mif.mem_we), 32'd0);
    chk_eq("rst_addr", 32'(mif.mem_addr), 32'd0);
    chk_eq("rst_wdata", 32'(mif.mem_wdata), 32'd0);
    chk_eq("rst_rd", 32'(rdData), 32'd0);
    rst = 1'b0;
    idle(2);

    // Zero-wait read.
    mem_model[16'h3000] = 16'h1234;
    do_txn(1'b0, 16'h3000, 16'h0000, 0, 1'b0);
    chk_eq("t1_rd", 32'(rdData), 32'h1234);
    idle(1);

    // Write with three wait states; rdData must be unchanged.
    do_txn(1'b1, 16'h4001, 16'hBEEF, 3, 1'b0);
    chk_eq("t2_rdkeep", 32'(rdData), 32'h1234);
    idle(1);

    // Read-after-write returns the written word.
    do_txn(1'b0, 16'h4001, 16'h0000, 2, 1'b0);
    chk_eq("t2_readback", 32'(rdData), 32'hBEEF);
    idle(1);

    do_conflict();
    idle(1);

    // Back-to-back: memRd held across R. mem_req must be low in the IDLE cycle.
    do_txn(1'b0, 16'h3000, 16'h0000, 1, 1'b1);
    MAR = 16'h4001;
    @(posedge clk);
    @(negedge clk);
    chk_eq("b2b_idle_req", 32'(mif.mem_req), 32'd0);
    chk_eq("b2b_idle_R", 32'(R), 32'd0);
    do_txn(1'b0, 16'h4001, 16'h0000, 0, 1'b0);
    chk_eq("b2b_rd", 32'(rdData), 32'hBEEF);
    idle(1);

    // Reset in REQ: abandon the access, clear rdData, and ignore a late ack.
    memRd = 1'b1;
    MAR   = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    chk_eq("rreq_req", 32'(mif.mem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    memRd = 1'b0;
    exp_rd = '0;
    chk_eq("rreq_reqlow", 32'(mif.mem_req), 32'd0);
    chk_eq("rreq_rd0", 32'(rdData), 32'd0);
    chk_eq("rreq_noR", 32'(R), 32'd0);
    chk_eq("rreq_noerr", 32'(memErr), 32'd0);
    mif.mem_ack = 1'b1;
    mif.mem_rdata = 16'hDEAD;
    @(posedge clk);
    @(negedge clk);
    mif.mem_ack = 1'b0;
    chk_eq("late_ack_noR", 32'(R), 32'd0);
    chk_eq("late_ack_req", 32'(mif.mem_req), 32'd0);
    idle(2);

`ifdef LC3_MEM_TIMEOUT_EN
    // No ack: four REQ cycles, then an aborted DONE with R and memErr together.
    memRd = 1'b1;
    MAR   = 16'h6000;
    exp_rd = 16'h0000;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_eq("to_req", 32'(mif.mem_req), 32'd1);
      chk_eq("to_noR", 32'(R), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    memRd = 1'b0;
    chk_eq("to_reqlow", 32'(mif.mem_req), 32'd0);
    chk_eq("to_R", 32'(R), 32'd1);
    chk_eq("to_err", 32'(memErr), 32'd1);
    chk_eq("to_rd0", 32'(rdData), 32'd0);
    idle(1);
`else
    // Without the watchdog, a long wait still completes normally.
    do_txn(1'b0, 16'h3000, 16'h0000, 70, 1'b0);
    chk_eq("longwait_rd", 32'(rdData), 32'h1234);
    idle(1);
`endif

    // Randomized mix of reads, writes, conflicts and back-to-back accesses.
    for (int t = 0; t < 60; t++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      wr = 1'($urandom_range(0, 1));
      a  = {12'h300, 4'($urandom_range(0, 7))};
      if (kind == 0) begin
        do_conflict();
      end else if (kind == 1) begin
        do_txn(wr, a, 16'($urandom), int'($urandom_range(0, MAXW)), 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk_eq("rb2b_idle_req", 32'(mif.mem_req), 32'd0);
        a = {12'h300, 4'($urandom_range(0, 7))};
        do_txn(wr, a, 16'($urandom), int'($urandom_range(0, MAXW)), 1'b0);
      end else begin
        do_txn(wr, a, 16'($urandom), int'($urandom_range(0, MAXW)), 1'b0);
      end
      idle(int'($urandom_range(1, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
